// File: rtl/snorm_arb_pkg.sv
// Shared helpers for the snorm_arb round-robin normalizing arbiter:
// id width and the signed saturation bounds for a given output width.
package snorm_arb_pkg;

    // Requester-index width; never narrower than one bit.
    function automatic int id_width(input int n);
        int w;
        w = $clog2(n);
        return (w < 1) ? 1 : w;
    endfunction

    // Largest positive value of a fw-bit two's-complement word, zero-extended to 64 bits.
    function automatic logic [63:0] sat_max(input int fw);
        return (64'd1 << (fw - 1)) - 64'd1;
    endfunction

    // Most negative value of a fw-bit two's-complement word; its low fw bits are 100...0.
    function automatic logic [63:0] sat_min(input int fw);
        return ~sat_max(fw);
    endfunction

endpackage

// File: rtl/snorm_sat.sv
// Combinational rescale of one signed fixed-point word from A_SCALE to F_SCALE
// fraction bits, fitted to F_WIDTH with overflow flag; saturates under SNORM_ARB_SAT_EN.
module snorm_sat
    import snorm_arb_pkg::*;
#(
    parameter int A_WIDTH = 32,
    parameter int A_SCALE = 12,
    parameter int F_WIDTH = 16,
    parameter int F_SCALE = 8
) (
    input  logic [A_WIDTH-1:0] a_i,
    output logic [F_WIDTH-1:0] f_o,
    output logic               ovf_o
);

    localparam int LSH = (F_SCALE >= A_SCALE) ? (F_SCALE - A_SCALE) : 0;
    localparam int RSH = (F_SCALE >= A_SCALE) ? 0 : (A_SCALE - F_SCALE);
    localparam int SHW = A_WIDTH + LSH;
    localparam int W   = (SHW > F_WIDTH) ? SHW : F_WIDTH;

    logic signed [W-1:0]       a_ext;
    logic signed [W-1:0]       shifted;
    logic signed [W-1:0]       wrap_ext;
    logic        [F_WIDTH-1:0] wrapped;

    // Sign-extend into a working width wide enough that the left shift cannot lose bits.
    always_comb begin
        a_ext = '0;
        for (int i = 0; i < W; i++) begin
            a_ext[i] = a_i[(i < A_WIDTH) ? i : (A_WIDTH - 1)];
        end
    end

    assign shifted = (a_ext <<< LSH) >>> RSH;
    assign wrapped = shifted[F_WIDTH-1:0];

    // Overflow means the kept bits, sign-extended back, do not reproduce the full value.
    always_comb begin
        wrap_ext = '0;
        for (int i = 0; i < W; i++) begin
            wrap_ext[i] = wrapped[(i < F_WIDTH) ? i : (F_WIDTH - 1)];
        end
    end

    assign ovf_o = (wrap_ext != shifted);

`ifdef SNORM_ARB_SAT_EN
    localparam logic [F_WIDTH-1:0] SAT_HI = F_WIDTH'(sat_max(F_WIDTH));
    localparam logic [F_WIDTH-1:0] SAT_LO = F_WIDTH'(sat_min(F_WIDTH));

    always_comb begin
        f_o = wrapped;
        if (ovf_o) begin
            f_o = shifted[W-1] ? SAT_LO : SAT_HI;
        end
    end
`else
    assign f_o = wrapped;
`endif

endmodule

// File: rtl/snorm_arb.sv
// Round-robin arbiter over N signed fixed-point requesters feeding one registered,
// rescaled output stage. Define SNORM_ARB_SAT_EN for saturating instead of wrapping.
module snorm_arb
    import snorm_arb_pkg::*;
#(
    parameter int N       = 4,
    parameter int A_WIDTH = 32,
    parameter int A_SCALE = 12,
    parameter int F_WIDTH = 16,
    parameter int F_SCALE = 8
) (
    input  logic                    clk,
    input  logic                    reset_l,
    input  logic [N-1:0]            req_valid,
    input  logic [N*A_WIDTH-1:0]    req_data,
    output logic [N-1:0]            req_ready,
    output logic                    out_valid,
    output logic [F_WIDTH-1:0]      out_data,
    output logic [id_width(N)-1:0]  out_id,
    output logic                    out_ovf,
    input  logic                    out_ready
);

    localparam int ID_W = id_width(N);

    // Handshake: a word moves on any rising edge where valid and ready are both high.
    // The output register loads when empty or drained this cycle (load_en); only then
    // may one requester see req_ready, so input and output transfers can coincide.

    logic                load_en;
    logic                gnt_found;
    logic [ID_W-1:0]     gnt_idx;
    logic [A_WIDTH-1:0]  gnt_data;
    logic [F_WIDTH-1:0]  sat_data;
    logic                sat_ovf;

    logic                out_valid_q, out_valid_d;
    logic [F_WIDTH-1:0]  out_data_q,  out_data_d;
    logic [ID_W-1:0]     out_id_q,    out_id_d;
    logic                out_ovf_q,   out_ovf_d;
    logic [ID_W-1:0]     ptr_q,       ptr_d;

    assign load_en = !out_valid_q || out_ready;

    // Scan from farthest to nearest so the nearest valid requester after ptr wins.
    always_comb begin
        gnt_found = 1'b0;
        gnt_idx   = '0;
        for (int k = N; k >= 1; k--) begin
            if (req_valid[(int'(ptr_q) + k) % N]) begin
                gnt_found = 1'b1;
                gnt_idx   = ID_W'((int'(ptr_q) + k) % N);
            end
        end
    end

    always_comb begin
        req_ready = '0;
        if (load_en && gnt_found) begin
            req_ready[gnt_idx] = 1'b1;
        end
    end

    assign gnt_data = req_data[int'(gnt_idx) * A_WIDTH +: A_WIDTH];

    snorm_sat #(
        .A_WIDTH (A_WIDTH),
        .A_SCALE (A_SCALE),
        .F_WIDTH (F_WIDTH),
        .F_SCALE (F_SCALE)
    ) u_sat (
        .a_i   (gnt_data),
        .f_o   (sat_data),
        .ovf_o (sat_ovf)
    );

    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_id_d    = out_id_q;
        out_ovf_d   = out_ovf_q;
        ptr_d       = ptr_q;
        if (load_en) begin
            out_valid_d = gnt_found;
            if (gnt_found) begin
                out_data_d = sat_data;
                out_id_d   = gnt_idx;
                out_ovf_d  = sat_ovf;
                ptr_d      = gnt_idx;
            end
        end
    end

    // ptr resets to N-1 so requester 0 is searched first.
    always_ff @(posedge clk or negedge reset_l) begin
        if (!reset_l) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_id_q    <= '0;
            out_ovf_q   <= 1'b0;
            ptr_q       <= ID_W'(N - 1);
        end else begin
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_id_q    <= out_id_d;
            out_ovf_q   <= out_ovf_d;
            ptr_q       <= ptr_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_id    = out_id_q;
    assign out_ovf   = out_ovf_q;

endmodule

// File: tb/tb_snorm_arb.sv
// Self-checking bench for snorm_arb: directed cases plus randomized traffic
// against a behavioural arbiter/scaler model and an output scoreboard.
module tb_snorm_arb;

    localparam int N  = 4;
    localparam int AW = 32;
    localparam int AS = 12;
    localparam int FW = 16;
    localparam int FS = 8;
    localparam int IW = 2;

    logic            clk = 1'b0;
    logic            reset_l;
    logic [N-1:0]    req_valid;
    logic [N*AW-1:0] req_data;
    logic [N-1:0]    req_ready;
    logic            out_valid;
    logic [FW-1:0]   out_data;
    logic [IW-1:0]   out_id;
    logic            out_ovf;
    logic            out_ready;

    snorm_arb #(.N(N), .A_WIDTH(AW), .A_SCALE(AS), .F_WIDTH(FW), .F_SCALE(FS)) dut (
        .clk       (clk),
        .reset_l   (reset_l),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_ready (req_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_id    (out_id),
        .out_ovf   (out_ovf),
        .out_ready (out_ready)
    );

    // clock/reset block
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // scoreboard: {ovf, id, data} of every accepted word, in acceptance order
    logic [FW+IW:0] exp_q[$];

    // model of the held output and the round-robin pointer
    logic          m_valid;
    logic [FW-1:0] m_data;
    logic [IW-1:0] m_id;
    logic          m_ovf;
    int            m_ptr;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
        end
    endtask

    // Value-level rescale: divide by 2^(AS-FS) rounding toward -inf, then fit to FW bits.
    function automatic void model_scale(input logic [AW-1:0] a, output logic [FW-1:0] f,
                                        output logic o);
        longint s;
        s = longint'($signed(a));
        s = s >>> (AS - FS);
        o = (s > 32767) || (s < -32768);
        f = s[FW-1:0];
`ifdef SNORM_ARB_SAT_EN
        if (o) f = (s > 0) ? 16'h7FFF : 16'h8000;
`endif
    endfunction

    task automatic model_reset();
        m_valid = 1'b0;
        m_data  = '0;
        m_id    = '0;
        m_ovf   = 1'b0;
        m_ptr   = N - 1;
        exp_q.delete();
    endtask

    function automatic logic [N*AW-1:0] lane(input int i, input logic [AW-1:0] w);
        logic [N*AW-1:0] v;
        v = '0;
        v[i*AW +: AW] = w;
        return v;
    endfunction

    function automatic logic [AW-1:0] rand_word();
        logic [AW-1:0] r;
        r = $urandom;
        if ($urandom_range(0, 3) != 0) r = {{12{r[19]}}, r[19:0]};
        return r;
    endfunction

    // One cycle: drive at negedge, compare everything at +1, advance model, wait next negedge.
    task automatic step(input logic [N-1:0] v, input logic [N*AW-1:0] d, input logic ordy);
        int            gi;
        logic          m_load;
        logic [N-1:0]  exp_rdy;
        logic [FW-1:0] f;
        logic          o;
        logic [FW+IW:0] front;
        req_valid = v;
        req_data  = d;
        out_ready = ordy;
        #1;
        chk("out_valid", {31'd0, out_valid}, {31'd0, m_valid});
        if (m_valid) begin
            chk("out_data", {16'd0, out_data}, {16'd0, m_data});
            chk("out_id", {30'd0, out_id}, {30'd0, m_id});
            chk("out_ovf", {31'd0, out_ovf}, {31'd0, m_ovf});
        end
        m_load = !m_valid || ordy;
        gi = -1;
        for (int k = 1; k <= N; k++) begin
            if (gi < 0 && v[(m_ptr + k) % N]) gi = (m_ptr + k) % N;
        end
        exp_rdy = '0;
        if (m_load && gi >= 0) exp_rdy[gi] = 1'b1;
        chk("req_ready", {28'd0, req_ready}, {28'd0, exp_rdy});
        if (out_valid && ordy) begin
            chk("sb_depth", exp_q.size(), 1);
            if (exp_q.size() > 0) begin
                front = exp_q.pop_front();
                chk("sb_word", {13'd0, out_ovf, out_id, out_data}, {13'd0, front});
            end
        end
        if (m_load) begin
            if (gi >= 0) begin
                model_scale(d[gi*AW +: AW], f, o);
                m_valid = 1'b1;
                m_data  = f;
                m_id    = gi[IW-1:0];
                m_ovf   = o;
                m_ptr   = gi;
                exp_q.push_back({o, gi[IW-1:0], f});
            end else begin
                m_valid = 1'b0;
            end
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    logic [N*AW-1:0] rd;
    logic [FW-1:0]   snap_data;
    logic [IW-1:0]   snap_id;

    initial begin
        reset_l   = 1'b0;
        req_valid = '0;
        req_data  = '0;
        out_ready = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_data", {16'd0, out_data}, 32'd0);
        chk("rst_id", {30'd0, out_id}, 32'd0);
        chk("rst_ovf", {31'd0, out_ovf}, 32'd0);
        reset_l = 1'b1;
        model_reset();

        // directed scaling cases
        step(4'b0001, lane(0, 32'h0000_1230), 1'b1);
        chk("scale_data", {16'd0, out_data}, 32'h0123);
        chk("scale_id", {30'd0, out_id}, 32'd0);
        chk("scale_ovf", {31'd0, out_ovf}, 32'd0);
        step(4'b0100, lane(2, 32'hFFFF_FFF1), 1'b1);
        chk("floor_data", {16'd0, out_data}, 32'hFFFF);
        chk("floor_ovf", {31'd0, out_ovf}, 32'd0);
        step(4'b0001, lane(0, 32'h0010_0000), 1'b1);
`ifdef SNORM_ARB_SAT_EN
        chk("ovf_pos_data", {16'd0, out_data}, 32'h7FFF);
`else
        chk("ovf_pos_data", {16'd0, out_data}, 32'h0000);
`endif
        chk("ovf_pos_flag", {31'd0, out_ovf}, 32'd1);
        step(4'b0010, lane(1, 32'hFFF0_0000), 1'b1);
`ifdef SNORM_ARB_SAT_EN
        chk("ovf_neg_data", {16'd0, out_data}, 32'h8000);
`else
        chk("ovf_neg_data", {16'd0, out_data}, 32'h0000);
`endif
        chk("ovf_neg_flag", {31'd0, out_ovf}, 32'd1);

        // fairness: last grant was requester 1, so rotation continues at 2
        for (int i = 0; i < 8; i++) begin
            for (int j = 0; j < N; j++) rd[j*AW +: AW] = rand_word();
            step(4'b1111, rd, 1'b1);
            chk("fair_id", {30'd0, out_id}, (i + 2) % N);
            chk("fair_valid", {31'd0, out_valid}, 32'd1);
        end

        // backpressure: output must freeze and no requester may be accepted
        snap_data = out_data;
        snap_id   = out_id;
        for (int i = 0; i < 5; i++) begin
            for (int j = 0; j < N; j++) rd[j*AW +: AW] = rand_word();
            step(4'b1111, rd, 1'b0);
            chk("bp_ready", {28'd0, req_ready}, 32'd0);
            chk("bp_data", {16'd0, out_data}, {16'd0, snap_data});
            chk("bp_id", {30'd0, out_id}, {30'd0, snap_id});
        end
        step(4'b1111, rd, 1'b1);

        // randomized traffic
        for (int i = 0; i < 400; i++) begin
            for (int j = 0; j < N; j++) rd[j*AW +: AW] = rand_word();
            step(4'($urandom), rd, ($urandom_range(0, 9) < 7));
        end

        // reset while a word is held
        step(4'b1111, rd, 1'b0);
        step(4'b1111, rd, 1'b0);
        reset_l = 1'b0;
        #1;
        chk("midrst_valid", {31'd0, out_valid}, 32'd0);
        chk("midrst_data", {16'd0, out_data}, 32'd0);
        model_reset();
        @(negedge clk);
        reset_l = 1'b1;
        step(4'b1111, rd, 1'b1);
        chk("postrst_id", {30'd0, out_id}, 32'd0);
        chk("postrst_valid", {31'd0, out_valid}, 32'd1);
        step(4'b0000, rd, 1'b1);
        chk("sb_final", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
